// File: rtl/luks_spi_pkg.sv
// Shared types and constants for the SPI responder/emulator blocks.
package luks_spi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        IGNORE = 3'd4
    } flash_resp_state_t;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int         CMD_BITS       = 8;
    localparam int         ADDR_BITS      = 24;

    // Next sequential byte address; the 24-bit add wraps 0xFFFFFF to 0x000000.
    function automatic logic [ADDR_BITS-1:0] addr_next(input logic [ADDR_BITS-1:0] addr);
        return addr + 24'd1;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronizes the SPI slave inputs into clk and derives sclk edge strobes.
// All outputs are registered and mutually aligned, so csb_s/mosi_s describe
// the same sample point as sclk_rise/sclk_fall.
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic sclk,
    input  logic csb,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csb_s,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] csb_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_prev_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   csb_r;
    logic                   mosi_r;

    // Metastability chains; csb idles deasserted (high) out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            csb_sync_r  <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sclk_sync_r[0] <= sclk;
            csb_sync_r[0]  <= csb;
            mosi_sync_r[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync_r[i] <= sclk_sync_r[i-1];
                csb_sync_r[i]  <= csb_sync_r[i-1];
                mosi_sync_r[i] <= mosi_sync_r[i-1];
            end
        end
    end

    // Edge detect on synchronized sclk plus matching delay on csb and mosi.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_prev_r <= 1'b0;
            rise_r      <= 1'b0;
            fall_r      <= 1'b0;
            csb_r       <= 1'b1;
            mosi_r      <= 1'b0;
        end else begin
            sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
            rise_r      <= sclk_sync_r[SYNC_STAGES-1] & ~sclk_prev_r;
            fall_r      <= ~sclk_sync_r[SYNC_STAGES-1] & sclk_prev_r;
            csb_r       <= csb_sync_r[SYNC_STAGES-1];
            mosi_r      <= mosi_sync_r[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = rise_r;
    assign sclk_fall = fall_r;
    assign csb_s     = csb_r;
    assign mosi_s    = mosi_r;

endmodule

// File: rtl/spi_flash_responder.sv
// Read-only serial flash emulator: answers mode-0 READ (0x03) frames from a
// byte-wide memory port with one-byte prefetch at each byte boundary.
module spi_flash_responder
    import luks_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sclk,
    input  logic        csb,
    input  logic        mosi,
    output logic        miso,
    output logic        mem_rd,
    output logic [23:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        busy,
    output logic        bad_cmd
);

    localparam logic [4:0] CMD_LAST  = 5'(CMD_BITS - 1);
    localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);

    logic sclk_rise_s;
    logic sclk_fall_s;
    logic csb_s;
    logic mosi_s;

    flash_resp_state_t state_r, state_n;
    logic [4:0]  bit_cnt_r, bit_cnt_n;
    logic [23:0] shift_r, shift_n;
    logic [7:0]  tx_r, tx_n;
    logic        miso_r, miso_n;
    logic        mem_rd_r, mem_rd_n;
    logic [23:0] mem_addr_r, mem_addr_n;
    logic        bad_cmd_r, bad_cmd_n;
    logic        busy_r;
    logic        load_r, load_n;
    logic [23:0] rx_word_s;

    spi_slave_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rstn      (rstn),
        .sclk      (sclk),
        .csb       (csb),
        .mosi      (mosi),
        .sclk_rise (sclk_rise_s),
        .sclk_fall (sclk_fall_s),
        .csb_s     (csb_s),
        .mosi_s    (mosi_s)
    );

    // Receive shift value including the bit sampled on this rise.
    assign rx_word_s = {shift_r[22:0], mosi_s};

    // Next-state and datapath update; csb high overrides everything.
    always_comb begin
        state_n    = state_r;
        bit_cnt_n  = bit_cnt_r;
        shift_n    = shift_r;
        tx_n       = tx_r;
        miso_n     = miso_r;
        mem_rd_n   = 1'b0;
        mem_addr_n = mem_addr_r;
        bad_cmd_n  = 1'b0;
        load_n     = 1'b0;

        if (csb_s) begin
            // Frame ended: drop partial bits and any in-flight prefetch.
            state_n   = IDLE;
            bit_cnt_n = 5'd0;
            shift_n   = 24'd0;
            tx_n      = 8'd0;
            miso_n    = 1'b0;
        end else begin
            // Read data returns the cycle after mem_rd; capture it then.
            load_n = mem_rd_r;
            if (load_r) begin
                tx_n = mem_data;
            end else begin
                tx_n = tx_r;
            end

            case (state_r)
                IDLE: begin
                    state_n   = CMD;
                    bit_cnt_n = 5'd0;
                    shift_n   = 24'd0;
                    miso_n    = 1'b0;
                end
                CMD: begin
                    miso_n = 1'b0;
                    if (sclk_rise_s) begin
                        shift_n = rx_word_s;
                        if (bit_cnt_r == CMD_LAST) begin
                            bit_cnt_n = 5'd0;
                            if (rx_word_s[7:0] == FLASH_CMD_READ) begin
                                state_n = ADDR;
                            end else begin
                                state_n   = IGNORE;
                                bad_cmd_n = 1'b1;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_r + 5'd1;
                        end
                    end else begin
                        shift_n = shift_r;
                    end
                end
                ADDR: begin
                    miso_n = 1'b0;
                    if (sclk_rise_s) begin
                        shift_n = rx_word_s;
                        if (bit_cnt_r == ADDR_LAST) begin
                            bit_cnt_n  = 5'd0;
                            state_n    = DATA;
                            mem_rd_n   = 1'b1;
                            mem_addr_n = rx_word_s;
                        end else begin
                            bit_cnt_n = bit_cnt_r + 5'd1;
                        end
                    end else begin
                        shift_n = shift_r;
                    end
                end
                DATA: begin
                    if (sclk_rise_s) begin
                        // Last bit of a byte sampled: fetch the following byte.
                        if (bit_cnt_r[2:0] == 3'd7) begin
                            bit_cnt_n  = 5'd0;
                            mem_rd_n   = 1'b1;
                            mem_addr_n = addr_next(mem_addr_r);
                        end else begin
                            bit_cnt_n = bit_cnt_r + 5'd1;
                        end
                    end else if (sclk_fall_s) begin
                        miso_n = tx_r[7];
                        tx_n   = {tx_r[6:0], 1'b0};
                    end else begin
                        miso_n = miso_r;
                    end
                end
                IGNORE: begin
                    miso_n = 1'b0;
                end
                default: begin
                    state_n   = IDLE;
                    bit_cnt_n = 5'd0;
                    miso_n    = 1'b0;
                end
            endcase
        end
    end

    // State, counters, shift registers and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 5'd0;
            shift_r    <= 24'd0;
            tx_r       <= 8'd0;
            miso_r     <= 1'b0;
            mem_rd_r   <= 1'b0;
            mem_addr_r <= 24'd0;
            bad_cmd_r  <= 1'b0;
            busy_r     <= 1'b0;
            load_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            bit_cnt_r  <= bit_cnt_n;
            shift_r    <= shift_n;
            tx_r       <= tx_n;
            miso_r     <= miso_n;
            mem_rd_r   <= mem_rd_n;
            mem_addr_r <= mem_addr_n;
            bad_cmd_r  <= bad_cmd_n;
            busy_r     <= ~csb_s;
            load_r     <= load_n;
        end
    end

    assign miso     = miso_r;
    assign mem_rd   = mem_rd_r;
    assign mem_addr = mem_addr_r;
    assign busy     = busy_r;
    assign bad_cmd  = bad_cmd_r;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder acting as an SPI mode-0 master.
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sclk;
    logic        csb;
    logic        mosi;
    logic        miso;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic        busy;
    logic        bad_cmd;

    int n_checks = 0;
    int n_fail   = 0;
    int half_per = 4;
    int mem_mode = 0;
    int busy_low = 0;

    logic [23:0] rd_q[$];
    int          bad_cnt  = 0;
    int          b2b_cnt  = 0;
    int          miso_hi  = 0;
    logic        prev_rd  = 1'b0;
    logic [7:0]  rx_bytes[4];

    always #5 clk = ~clk;

    spi_flash_responder #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sclk     (sclk),
        .csb      (csb),
        .mosi     (mosi),
        .miso     (miso),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .bad_cmd  (bad_cmd)
    );

    // Memory model: data valid the cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_rd) begin
            if (mem_mode != 0) mem_data <= mem_addr[0] ? 8'h5A : 8'hA5;
            else               mem_data <= mem_addr[7:0];
        end
    end

    // Output monitors sampled away from the active edge.
    always @(negedge clk) begin
        if (mem_rd) rd_q.push_back(mem_addr);
        if (mem_rd && prev_rd) b2b_cnt <= b2b_cnt + 1;
        prev_rd <= mem_rd;
        if (bad_cmd) bad_cnt <= bad_cnt + 1;
        if (miso) miso_hi <= miso_hi + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One frame of nbits clocks: opcode, address, then data bits with mosi low.
    // rst_bit >= 0 pulses rstn just after sampling that bit and ends the frame.
    task automatic spi_frame(input logic [7:0] op, input logic [23:0] addr,
                             input int nbits, input int rst_bit);
        logic [31:0] hdr;
        hdr = {op, addr};
        busy_low = 0;
        for (int k = 0; k < 4; k++) rx_bytes[k] = 8'h00;
        @(negedge clk);
        csb = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = (i < 32) ? hdr[31-i] : 1'b0;
            repeat (half_per) @(negedge clk);
            if (busy !== 1'b1) busy_low++;
            if (i >= 32) rx_bytes[(i-32)/8][7-((i-32)%8)] = miso;
            if (i == rst_bit) begin
                rstn = 1'b0;
                #1;
                check_eq("rst_miso", {31'd0, miso}, 32'd0);
                check_eq("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
                check_eq("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
                check_eq("rst_busy", {31'd0, busy}, 32'd0);
                check_eq("rst_bad_cmd", {31'd0, bad_cmd}, 32'd0);
                @(negedge clk);
                rstn = 1'b1;
                break;
            end
            sclk = 1'b1;
            repeat (half_per) @(negedge clk);
        end
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (half_per) @(negedge clk);
        csb = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    int base;
    int b0;
    int m0;

    initial begin
        rstn = 1'b0;
        sclk = 1'b0;
        csb  = 1'b1;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("reset_miso", {31'd0, miso}, 32'd0);
        check_eq("reset_mem_rd", {31'd0, mem_rd}, 32'd0);
        check_eq("reset_mem_addr", {8'd0, mem_addr}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_bad_cmd", {31'd0, bad_cmd}, 32'd0);

        // READ at 0x10, two data bytes, slower SCLK.
        half_per = 6;
        base = rd_q.size();
        b0 = bad_cnt;
        spi_frame(8'h03, 24'h000010, 48, -1);
        check_eq("t1_byte0", {24'd0, rx_bytes[0]}, 32'h10);
        check_eq("t1_byte1", {24'd0, rx_bytes[1]}, 32'h11);
        check_eq("t1_rd0_addr", {8'd0, rd_q[base]}, 32'h000010);
        check_eq("t1_rd1_addr", {8'd0, rd_q[base+1]}, 32'h000011);
        check_eq("t1_rd_count_le3", {31'd0, (rd_q.size() - base) <= 3}, 32'd1);
        check_eq("t1_busy_low_samples", busy_low, 32'd0);
        check_eq("t1_no_bad_cmd", bad_cnt - b0, 32'd0);
        check_eq("t1_busy_after", {31'd0, busy}, 32'd0);

        // Unsupported opcode 0x9F followed by 24 clocks.
        half_per = 4;
        base = rd_q.size();
        b0 = bad_cnt;
        m0 = miso_hi;
        spi_frame(8'h9F, 24'hABCDEF, 32, -1);
        check_eq("t2_bad_cmd_pulses", bad_cnt - b0, 32'd1);
        check_eq("t2_miso_high_cycles", miso_hi - m0, 32'd0);
        check_eq("t2_rd_count", rd_q.size() - base, 32'd0);

        // Abort after 12 address bits, then a full READ at 0x20.
        base = rd_q.size();
        spi_frame(8'h03, 24'h000020, 20, -1);
        check_eq("t3_abort_rd_count", rd_q.size() - base, 32'd0);
        base = rd_q.size();
        spi_frame(8'h03, 24'h000020, 40, -1);
        check_eq("t3_byte0", {24'd0, rx_bytes[0]}, 32'h20);
        check_eq("t3_rd0_addr", {8'd0, rd_q[base]}, 32'h000020);

        // Address wrap at the top of the space.
        base = rd_q.size();
        spi_frame(8'h03, 24'hFFFFFF, 48, -1);
        check_eq("t4_rd0_addr", {8'd0, rd_q[base]}, 32'hFFFFFF);
        check_eq("t4_rd1_addr", {8'd0, rd_q[base+1]}, 32'h000000);
        check_eq("t4_byte0", {24'd0, rx_bytes[0]}, 32'hFF);
        check_eq("t4_byte1", {24'd0, rx_bytes[1]}, 32'h00);

        // Reset mid-DATA while miso carries bit 7 of 0xA5.
        mem_mode = 1;
        spi_frame(8'h03, 24'h000100, 64, 32);
        check_eq("t5_miso_before_rst", {31'd0, rx_bytes[0][7]}, 32'd1);

        // Full READ after reset at minimum SCLK period: 0xA5 then 0x5A.
        base = rd_q.size();
        spi_frame(8'h03, 24'h000100, 48, -1);
        check_eq("t6_byte0", {24'd0, rx_bytes[0]}, 32'hA5);
        check_eq("t6_byte1", {24'd0, rx_bytes[1]}, 32'h5A);
        check_eq("t6_rd0_addr", {8'd0, rd_q[base]}, 32'h000100);
        check_eq("t6_rd1_addr", {8'd0, rd_q[base+1]}, 32'h000101);

        check_eq("no_back_to_back_rd", b2b_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI slave that emulates a read-only serial flash. It answers the flash SPI master's READ (0x03) transactions from a byte-wide memory read port. It sits on the far end of the flash SCLK/SS/MOSI/MISO lines, either on a companion test tile or in the bench harness, so the FSM's flash path can be exercised without a real device. It is SPI mode 0 and fully synchronous to `clk`, with SPI inputs oversampled.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `sclk`, `csb` and `mosi`.
- `clk` in 1: system clock. One clock; all logic on its rising edge.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `sclk` in 1: SPI clock from master. Asynchronous to `clk`.
- `csb` in 1: chip select, active-low.
- `mosi` in 1: master-out data.
- `miso` out 1: slave-out data. Driven low whenever not in DATA state.
- `mem_rd` out 1: one-cycle read strobe.
- `mem_addr` out 24: byte address for the current `mem_rd`.
- `mem_data` in 8: read data, valid exactly 1 cycle after `mem_rd`.
- `busy` out 1: high while `csb` (synchronized) is low.
- `bad_cmd` out 1: one-cycle pulse when a non-0x03 opcode completes.

## Operation
- Inputs pass through `SYNC_STAGES` flops. Edge detect on synchronized `sclk` gives `rise` and `fall` strobes.
- Mode 0 protocol:
  - MOSI is sampled on `rise`, MSB first.
  - MISO is updated on `fall`, MSB first.
- State machine states: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE: `csb` falls → CMD, clear bit counter.
  - CMD: shift 8 bits. On the 8th `rise`:
    - opcode 0x03 → ADDR.
    - any other opcode → IGNORE, and pulse `bad_cmd`.
  - ADDR: shift 24 bits. On the 24th `rise`, go to DATA. On the next cycle, assert `mem_rd` with `mem_addr` = received address.
  - DATA:
    - The returned `mem_data` loads the tx shift register. Bit 7 is presented on the next `fall`, i.e. the 32nd falling edge of the transaction, so the master samples it on `rise` 33.
    - Each later `fall` shifts the next bit out.
    - On every 8th data `rise`: address increments, `mem_rd` reissues (prefetch), and the new byte loads at the byte boundary.
  - IGNORE: `miso` = 0 until `csb` rises.
- Any state, synchronized `csb` high → IDLE the same cycle. Counters and shift registers clear, `miso` = 0, and any pending prefetch is discarded.
- Address wraps 0xFFFFFF → 0x000000 silently.
- `rise` and `csb` deassert in the same cycle: `csb` wins and the bit is dropped.

## Timing
- Reset values: `miso` 0, `mem_rd` 0, `mem_addr` 0, `busy` 0, `bad_cmd` 0, state IDLE.
- Input-to-internal latency is `SYNC_STAGES` + 1 cycles (edge detect).
- Required SCLK high and low times are each ≥ 4 `clk` cycles (SCLK period ≥ 8 `clk`). The memory round trip (`mem_rd` → load) is 2 cycles after `rise`, so it completes before the following `fall`.
- `csb` setup to first `sclk` rise must be ≥ 4 `clk`.
- `miso` changes 1 cycle after the `fall` strobe, and only then.
- `mem_rd` is never asserted on consecutive cycles. There is at most one read per byte.
- `bad_cmd` is asserted 1 cycle after the 8th opcode `rise`.

## Structure
- Package `luks_spi_pkg`:
  - state enum `flash_resp_state_t`.
  - `FLASH_CMD_READ` = 8'h03.
  - `CMD_BITS` = 8.
  - `ADDR_BITS` = 24.
- Sub-module `spi_slave_sync` contains the synchronizer chain plus `sclk` edge detect. It outputs `sclk_rise`, `sclk_fall`, `csb_s` and `mosi_s`, and is reusable for a future light-sensor emulator.
- Top-level FSM, counters and shift registers stay in `spi_flash_responder`.

## Test plan
- READ 0x03, addr 0x000010, 16 data clocks, with memory returning `addr[7:0]` → master receives 0x10 then 0x11. Two `mem_rd` pulses for the data bytes, at `mem_addr` 0x000010 and 0x000011 (the prefetch for 0x000012 at the end is discarded by `csb`). `busy` high throughout.
- Opcode 0x9F followed by 24 clocks → `bad_cmd` pulses once, `miso` stays 0, no `mem_rd`.
- `csb` rises after 12 address bits, then a new READ at 0x000020 → no `mem_rd` from the aborted frame. The second frame returns the byte from 0x20.
- READ at 0xFFFFFF for 2 bytes → `mem_addr` sequence 0xFFFFFF, 0x000000.
- `rstn` pulsed low mid-DATA → all outputs at reset values immediately. The next full READ works normally.
- SCLK period exactly 8 `clk`, bytes 0xA5 then 0x5A → bit-exact `miso` with no slips at the byte boundary.
